// File: rtl/line_tap_buffer.sv
// rtl/line_tap_buffer.sv - multi-line tap buffer producing TAPS_P-pixel vertical columns
// Cascaded circular line RAMs with one output register and valid/ready on both sides.
module line_tap_buffer #(
    parameter int WIDTH_P = 8,
    parameter int LINE_P  = 640,
    parameter int TAPS_P  = 3,
    parameter int PRIME_P = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        sof_i,
    input  logic [WIDTH_P-1:0]          data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [TAPS_P*WIDTH_P-1:0]   data_o,
    output logic [$clog2(LINE_P)-1:0]   col_o,
    output logic                        primed_o
);
    localparam int COL_W = $clog2(LINE_P);
    localparam int CNT_W = $clog2(TAPS_P);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_P - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS_P - 1);

    logic [WIDTH_P-1:0]        ram_q [TAPS_P-1][LINE_P];
    logic [COL_W-1:0]          col_q, col_d, col_cur;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_cur;
    logic                      valid_q, valid_d;
    logic [TAPS_P*WIDTH_P-1:0] data_q, data_d, tap_col;
    logic [COL_W-1:0]          ocol_q, ocol_d;
    logic                      primed_q, primed_d;
    logic                      accept, wrap, primed_cur, load;

    assign ready_o = !valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    // A start-of-frame pixel sees column 0 and an empty line count in the same cycle.
    always_comb begin
        col_cur    = sof_i ? '0 : col_q;
        cnt_cur    = sof_i ? '0 : cnt_q;
        wrap       = (col_cur == LAST_COL);
        primed_cur = (cnt_cur == FULL_CNT);
        load       = accept & ((PRIME_P == 0) | primed_cur);
    end

    always_comb begin
        tap_col = '0;
        tap_col[WIDTH_P-1:0] = data_i;
        for (int k = 1; k < TAPS_P; k++) begin
            tap_col[k*WIDTH_P +: WIDTH_P] = ram_q[k-1][col_cur];
        end
    end

    always_comb begin
        col_d    = col_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ocol_d   = ocol_q;
        primed_d = primed_q;
        if (ready_o) begin
            valid_d = load;
        end
        if (accept) begin
            col_d    = wrap ? '0 : col_cur + 1'b1;
            cnt_d    = (wrap && !primed_cur) ? cnt_cur + 1'b1 : cnt_cur;
            primed_d = primed_cur;
        end
        if (load) begin
            data_d = tap_col;
            ocol_d = col_cur;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ocol_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ocol_q   <= ocol_d;
            primed_q <= primed_d;
        end
    end

    // Read-before-write cascade: each RAM takes the old content of the one above it.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            ram_q[0][col_cur] <= data_i;
            for (int k = 1; k < TAPS_P - 1; k++) begin
                ram_q[k][col_cur] <= ram_q[k-1][col_cur];
            end
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign col_o    = ocol_q;
    assign primed_o = primed_q;
endmodule

// File: tb/tb_line_tap_buffer.sv
// tb/tb_line_tap_buffer.sv - self-checking bench for line_tap_buffer
module tb_line_tap_buffer;
    localparam int W = 8;
    localparam int L = 4;
    localparam int T = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, sof_i, ready_i, ready_o, valid_o, primed_o;
    logic [W-1:0]  data_i;
    logic [T*W-1:0] data_o;
    logic [1:0]    col_o;
    logic          v0, s0, r0, ro0, vo0, po0;
    logic [W-1:0]  d0;
    logic [T*W-1:0] do0;
    logic [1:0]    co0;

    int n_vec = 0;
    int n_err = 0;

    // Reference: the current frame's pixels in arrival order, plus the output slot.
    int            hist[$];
    logic          m_valid, m_primed;
    logic [T*W-1:0] m_data;
    logic [1:0]    m_col;
    logic          exp_ready, obs_ready;

    always #5 clk = ~clk;

    line_tap_buffer #(.WIDTH_P(W), .LINE_P(L), .TAPS_P(T), .PRIME_P(1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .sof_i(sof_i),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .col_o(col_o), .primed_o(primed_o)
    );

    line_tap_buffer #(.WIDTH_P(W), .LINE_P(L), .TAPS_P(T), .PRIME_P(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(v0), .ready_o(ro0), .sof_i(s0),
        .data_i(d0), .valid_o(vo0), .ready_i(r0), .data_o(do0),
        .col_o(co0), .primed_o(po0)
    );

    task automatic model_clear();
        hist.delete();
        m_valid  = 1'b0;
        m_primed = 1'b0;
        m_data   = '0;
        m_col    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, advance the model on the edge, return at next negedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic s, input logic r);
        bit acc;
        int idx;
        valid_i = v; data_i = d; sof_i = s; ready_i = r;
        exp_ready = !m_valid | r;
        #1 obs_ready = ready_o;
        acc = v & exp_ready;
        @(posedge clk);
        if (acc) begin
            if (s) hist.delete();
            idx = hist.size();
            hist.push_back(int'(d));
            m_primed = (idx >= (T-1)*L);
            m_valid  = m_primed;
            if (m_primed) begin
                m_col = 2'(idx % L);
                for (int k = 0; k < T; k++) m_data[k*W +: W] = 8'(hist[idx - k*L]);
            end
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({valid_o, data_o, col_o, primed_o, ready_o} !== {1'b0, 24'h0, 2'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state got v=%b d=%h c=%0d p=%b r=%b want 0/000000/0/0/1",
                     valid_o, data_o, col_o, primed_o, ready_o);
        end
        ready_i = 1'b0;
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_empty got %b want 1", ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
    endtask

    task automatic test_prime0();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v0 = 1'b1; d0 = 8'(i); s0 = 1'b0; r0 = 1'b1;
            @(posedge clk);
            #1;
            n_vec++;
            if (vo0 !== 1'b1 || do0[7:0] !== 8'(i) || co0 !== 2'(i % L) ||
                (i == 5 && do0[15:8] !== 8'd1)) begin
                n_err++;
                $display("FAIL prime0_px%0d got v=%b d=%h c=%0d want v=1 s0=%0d c=%0d",
                         i, vo0, do0, co0, i, i % L);
            end
        end
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic test_priming();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b1);
            n_vec++;
            if ({obs_ready, valid_o, primed_o, col_o, data_o} !== {exp_ready, m_valid, m_primed, m_col, m_data} ||
                ((i == 8 || i == 11 || i == 12) &&
                 {valid_o, data_o} !== {1'b1, 8'(i-8), 8'(i-4), 8'(i)})) begin
                n_err++;
                $display("FAIL priming_px%0d got r=%b v=%b p=%b c=%0d d=%h want r=%b v=%b p=%b c=%0d d=%h",
                         i, obs_ready, valid_o, primed_o, col_o, data_o,
                         exp_ready, m_valid, m_primed, m_col, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 8'd10, 1'b0, 1'b0);
            n_vec++;
            if ({obs_ready, valid_o, col_o, data_o} !== {exp_ready, m_valid, m_col, m_data} ||
                {ready_o, data_o} !== {1'b0, 24'h010509}) begin
                n_err++;
                $display("FAIL backpressure_hold%0d got r=%b v=%b c=%0d d=%h want r=0 d=010509",
                         j, ready_o, valid_o, col_o, data_o);
            end
        end
        cycle(1'b1, 8'd10, 1'b0, 1'b1);
        n_vec++;
        if ({valid_o, col_o, data_o} !== {1'b1, 2'd2, 24'h02060A} ||
            {valid_o, col_o, data_o} !== {m_valid, m_col, m_data}) begin
            n_err++;
            $display("FAIL backpressure_resume got v=%b c=%0d d=%h want v=1 c=2 d=02060a",
                     valid_o, col_o, data_o);
        end
    endtask

    task automatic test_sof();
        for (int i = 11; i < 13; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        for (int j = 0; j < 9; j++) begin
            cycle(1'b1, 8'(j == 0 ? 13 : $urandom), j == 0, 1'b1);
            n_vec++;
            if ({valid_o, primed_o, col_o, data_o} !== {m_valid, m_primed, m_col, m_data} ||
                (j < 8 && {valid_o, primed_o} !== 2'b00) ||
                (j == 8 && {valid_o, primed_o, col_o} !== {1'b1, 1'b1, 2'd0})) begin
                n_err++;
                $display("FAIL sof_acc%0d got v=%b p=%b c=%0d d=%h want v=%b p=%b c=%0d d=%h",
                         j, valid_o, primed_o, col_o, data_o, m_valid, m_primed, m_col, m_data);
            end
        end
    endtask

    task automatic test_random();
        logic v, s, r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(v, 8'($urandom), s, r);
            n_vec++;
            if ({obs_ready, valid_o, primed_o, col_o, data_o} !== {exp_ready, m_valid, m_primed, m_col, m_data}) begin
                n_err++;
                $display("FAIL random_cyc%0d got r=%b v=%b p=%b c=%0d d=%h want r=%b v=%b p=%b c=%0d d=%h",
                         i, obs_ready, valid_o, primed_o, col_o, data_o,
                         exp_ready, m_valid, m_primed, m_col, m_data);
            end
        end
    endtask

    task automatic test_reset_midline();
        cycle(1'b1, 8'd0, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        #2 rst = 1'b1;
        model_clear();
        #1;
        n_vec++;
        if ({valid_o, data_o, primed_o} !== {1'b0, 24'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_midline_async got v=%b d=%h p=%b want 0/000000/0",
                     valid_o, data_o, primed_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 9; j++) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
            n_vec++;
            if ({valid_o, primed_o, col_o, data_o} !== {m_valid, m_primed, m_col, m_data} ||
                (j < 8 && valid_o !== 1'b0) || (j == 8 && {valid_o, col_o} !== {1'b1, 2'd0})) begin
                n_err++;
                $display("FAIL reset_midline_acc%0d got v=%b p=%b c=%0d d=%h want v=%b p=%b c=%0d d=%h",
                         j, valid_o, primed_o, col_o, data_o, m_valid, m_primed, m_col, m_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; sof_i = 1'b0; data_i = '0; ready_i = 1'b1;
        v0 = 1'b0; s0 = 1'b0; d0 = '0; r0 = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        test_reset();
        test_prime0();
        test_priming();
        test_backpressure();
        test_sof();
        test_random();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
